// File: rtl/xillybus_wrapper_acc_pkg.sv
// rtl/xillybus_wrapper_acc_pkg.sv - shared types and constants for the product accumulator
// Purpose: FSM state encoding, default widths and the signed output clamp limits.
// Ports: none (package).
package xillybus_wrapper_acc_pkg;

    localparam int IN_WIDTH_DEF  = 30;
    localparam int LEN_WIDTH_DEF = 16;
    localparam int ACC_WIDTH_DEF = 46;
    localparam int OUT_WIDTH_DEF = 32;

    // Largest and smallest representable signed results at the default output width.
    localparam logic [OUT_WIDTH_DEF-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH_DEF-1){1'b1}}};
    localparam logic [OUT_WIDTH_DEF-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH_DEF-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_SAT   = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

endpackage

// File: rtl/xillybus_wrapper_sat.sv
// rtl/xillybus_wrapper_sat.sv - combinational signed clamp from accumulator to output width
// Purpose: narrow a wide signed sum to OUT_WIDTH, clamping to the signed limits.
// Ports: acc (in, ACC_WIDTH signed sum), sat_result (out, OUT_WIDTH), sat_flag (out, clamp occurred).
module xillybus_wrapper_sat
    import xillybus_wrapper_acc_pkg::*;
#(
    parameter int ACC_WIDTH = ACC_WIDTH_DEF,
    parameter int OUT_WIDTH = OUT_WIDTH_DEF
) (
    input  logic [ACC_WIDTH-1:0] acc,
    output logic [OUT_WIDTH-1:0] sat_result,
    output logic                 sat_flag
);

    localparam logic [OUT_WIDTH-1:0] SAT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] SAT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    // The value fits iff every bit from the output sign bit upward is a copy of it.
    logic [ACC_WIDTH-OUT_WIDTH:0] hi_bits;
    logic                         fits;

    assign hi_bits = acc[ACC_WIDTH-1:OUT_WIDTH-1];
    assign fits    = (&hi_bits) || (~|hi_bits);

    always_comb begin
        sat_result = acc[OUT_WIDTH-1:0];
        sat_flag   = 1'b0;
        if (!fits) begin
            sat_flag   = 1'b1;
            sat_result = acc[ACC_WIDTH-1] ? SAT_MIN : SAT_MAX;
        end
    end

endmodule

// File: rtl/xillybus_wrapper_acc.sv
// rtl/xillybus_wrapper_acc.sv - frame accumulator feeding the host-bound Xillybus FIFO
// Purpose: sum len signed products (one per cycle), clamp to OUT_WIDTH, write one word per frame.
// Ports: ap_clk/ap_rst (clock, sync active-high reset); ap_start/ap_done/ap_idle (block control);
//        len (frame length, sampled on start); prod_dout/prod_empty_n/prod_read (product FIFO read side);
//        acc_din/acc_full_n/acc_write (host FIFO write side); sat_flag (last result was clamped).
module xillybus_wrapper_acc
    import xillybus_wrapper_acc_pkg::*;
#(
    parameter int IN_WIDTH  = IN_WIDTH_DEF,
    parameter int LEN_WIDTH = LEN_WIDTH_DEF,
    parameter int ACC_WIDTH = ACC_WIDTH_DEF,
    parameter int OUT_WIDTH = OUT_WIDTH_DEF
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic                 ap_start,
    output logic                 ap_done,
    output logic                 ap_idle,
    input  logic [LEN_WIDTH-1:0] len,
    input  logic [IN_WIDTH-1:0]  prod_dout,
    input  logic                 prod_empty_n,
    output logic                 prod_read,
    output logic [OUT_WIDTH-1:0] acc_din,
    input  logic                 acc_full_n,
    output logic                 acc_write,
    output logic                 sat_flag
);

    state_t                 state_q, state_d;
    logic [LEN_WIDTH-1:0]   remaining_q, remaining_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [OUT_WIDTH-1:0]   acc_din_q, acc_din_d;
    logic                   sat_flag_q, sat_flag_d;

    logic [ACC_WIDTH-1:0]   prod_ext;
    logic [OUT_WIDTH-1:0]   clamp_result;
    logic                   clamp_flag;

    assign prod_ext = {{(ACC_WIDTH-IN_WIDTH){prod_dout[IN_WIDTH-1]}}, prod_dout};

    xillybus_wrapper_sat #(
        .ACC_WIDTH (ACC_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_sat (
        .acc        (acc_q),
        .sat_result (clamp_result),
        .sat_flag   (clamp_flag)
    );

    // Handshake outputs are pure functions of state and the peer's ready/valid.
    assign ap_idle   = (state_q == ST_IDLE);
    assign prod_read = (state_q == ST_ACC) && prod_empty_n;
    assign acc_write = (state_q == ST_WRITE) && acc_full_n;
    assign ap_done   = acc_write;
    assign acc_din   = acc_din_q;
    assign sat_flag  = sat_flag_q;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        acc_d       = acc_q;
        acc_din_d   = acc_din_q;
        sat_flag_d  = sat_flag_q;
        case (state_q)
            ST_IDLE: begin
                if (ap_start) begin
                    remaining_d = len;
                    acc_d       = '0;
                    // An empty frame still produces a (zero) result word.
                    state_d     = (len == '0) ? ST_SAT : ST_ACC;
                end
            end
            ST_ACC: begin
                if (prod_empty_n) begin
                    acc_d       = acc_q + prod_ext;
                    remaining_d = remaining_q - LEN_WIDTH'(1);
                    if (remaining_q == LEN_WIDTH'(1)) begin
                        state_d = ST_SAT;
                    end
                end
            end
            ST_SAT: begin
                acc_din_d  = clamp_result;
                sat_flag_d = clamp_flag;
                state_d    = ST_WRITE;
            end
            ST_WRITE: begin
                if (acc_full_n) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            acc_q       <= '0;
            acc_din_q   <= '0;
            sat_flag_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            acc_q       <= acc_d;
            acc_din_q   <= acc_din_d;
            sat_flag_q  <= sat_flag_d;
        end
    end

endmodule

// File: tb/tb_xillybus_wrapper_acc.sv
// tb/tb_xillybus_wrapper_acc.sv - self-checking bench for xillybus_wrapper_acc
module tb_xillybus_wrapper_acc;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        ap_start;
    logic        ap_done;
    logic        ap_idle;
    logic [15:0] len;
    logic [29:0] prod_dout;
    logic        prod_empty_n;
    logic        prod_read;
    logic [31:0] acc_din;
    logic        acc_full_n;
    logic        acc_write;
    logic        sat_flag;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int prod_q[$];

    always #5 ap_clk = ~ap_clk;
    always @(posedge ap_clk) cyc <= cyc + 1;

    xillybus_wrapper_acc dut (
        .ap_clk       (ap_clk),
        .ap_rst       (ap_rst),
        .ap_start     (ap_start),
        .ap_done      (ap_done),
        .ap_idle      (ap_idle),
        .len          (len),
        .prod_dout    (prod_dout),
        .prod_empty_n (prod_empty_n),
        .prod_read    (prod_read),
        .acc_din      (acc_din),
        .acc_full_n   (acc_full_n),
        .acc_write    (acc_write),
        .sat_flag     (sat_flag)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: exact integer sum, then clamp to the signed 32-bit range.
    function automatic logic [32:0] model_result(input longint s);
        logic [63:0] sv;
        sv = s;
        if (s > 64'sd2147483647)       return {1'b1, 32'h7FFF_FFFF};
        else if (s < -64'sd2147483648) return {1'b1, 32'h8000_0000};
        else                           return {1'b0, sv[31:0]};
    endfunction

    // Runs one frame using the products in prod_q.
    // pattern: 0 = data always present, 1 = present every other cycle, 2 = random.
    task automatic run_frame(input int n, input int pattern, input int full_stall, input bit busy_pulse);
        longint      sum = 0;
        logic [32:0] exp;
        int          s_cyc, last, reads, stalls, tmp;
        bit          done, en, in_wr;
        for (int i = 0; i < prod_q.size(); i++) sum += prod_q[i];
        exp = model_result(sum);

        @(negedge ap_clk);
        ap_start = 1'b1; len = n[15:0]; prod_empty_n = 1'b0; acc_full_n = 1'b1;
        #1;
        check("idle_at_start", {31'b0, ap_idle}, 32'd1);
        s_cyc = cyc; last = s_cyc; reads = 0; stalls = full_stall; done = 1'b0;

        for (int t = 0; t < 400 && !done; t++) begin
            @(negedge ap_clk);
            ap_start = busy_pulse ? 1'($urandom_range(0, 1)) : 1'b0;
            case (pattern)
                0:       en = 1'b1;
                1:       en = ((cyc - s_cyc) % 2) == 1;
                default: en = 1'($urandom_range(0, 1));
            endcase
            prod_empty_n = en && (prod_q.size() > 0);
            tmp = (prod_q.size() > 0) ? prod_q[0] : 0;
            prod_dout = tmp[29:0];
            in_wr = (reads == n) && (cyc >= last + 2);
            acc_full_n = !(in_wr && stalls > 0);
            if (in_wr && stalls > 0) stalls--;
            #1;
            if (prod_read) begin
                reads++;
                last = cyc;
                if (prod_q.size() > 0) void'(prod_q.pop_front());
            end
            if (acc_write) begin
                check("done_with_write", {31'b0, ap_done}, 32'd1);
                check("acc_din", acc_din, exp[31:0]);
                check("sat_flag", {31'b0, sat_flag}, {31'b0, exp[32]});
                check("write_latency", cyc - last, 32'(2 + full_stall));
                done = 1'b1;
            end else begin
                check("done_without_write", {31'b0, ap_done}, 32'd0);
                if (in_wr && !acc_full_n) check("acc_din_stalled", acc_din, exp[31:0]);
            end
        end
        if (!done) check("frame_timeout", 32'd0, 32'd1);
        check("read_count", reads, n);

        for (int t = 0; t < 2; t++) begin
            @(negedge ap_clk);
            ap_start = 1'b0; prod_empty_n = 1'b1; acc_full_n = 1'b1;
            #1;
            check("post_idle", {31'b0, ap_idle}, 32'd1);
            check("post_no_read", {31'b0, prod_read}, 32'd0);
            check("post_no_write", {31'b0, acc_write}, 32'd0);
        end
        prod_q.delete();
    endtask

    initial begin
        int n, mode, reads;
        ap_rst = 1'b1; ap_start = 1'b0; len = '0; prod_dout = '0;
        prod_empty_n = 1'b1; acc_full_n = 1'b1;
        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        #1;
        check("rst_idle", {31'b0, ap_idle}, 32'd1);
        check("rst_done", {31'b0, ap_done}, 32'd0);
        check("rst_read", {31'b0, prod_read}, 32'd0);
        check("rst_write", {31'b0, acc_write}, 32'd0);
        check("rst_acc_din", acc_din, 32'd0);
        check("rst_sat_flag", {31'b0, sat_flag}, 32'd0);
        ap_rst = 1'b0;

        // Basic frame
        prod_q = '{100, -50, 1000, 7};
        run_frame(4, 0, 0, 1'b0);
        // Empty frame
        run_frame(0, 0, 0, 1'b0);
        // Saturation both ways, then a small unsaturated frame
        for (int i = 0; i < 5; i++) prod_q.push_back(536870911);
        run_frame(5, 0, 0, 1'b0);
        for (int i = 0; i < 5; i++) prod_q.push_back(-536870912);
        run_frame(5, 0, 0, 1'b0);
        prod_q = '{3};
        run_frame(1, 0, 0, 1'b0);
        // Backpressure on both sides
        prod_q = '{11, -22, 33};
        run_frame(3, 1, 10, 1'b0);
        // Start pulses while busy
        prod_q = '{5, 6, 7};
        run_frame(3, 2, 3, 1'b1);

        // Reset in the middle of a frame after two reads
        @(negedge ap_clk);
        ap_start = 1'b1; len = 16'd4; prod_empty_n = 1'b0; acc_full_n = 1'b1;
        reads = 0;
        for (int t = 0; t < 2; t++) begin
            @(negedge ap_clk);
            ap_start = 1'b0; prod_empty_n = 1'b1; prod_dout = 30'd1000;
            #1;
            if (prod_read) reads++;
        end
        check("pre_reset_reads", reads, 32'd2);
        @(negedge ap_clk);
        ap_rst = 1'b1; prod_empty_n = 1'b0;
        @(negedge ap_clk);
        ap_rst = 1'b0; prod_empty_n = 1'b1;
        #1;
        check("reset_idle", {31'b0, ap_idle}, 32'd1);
        check("reset_no_read", {31'b0, prod_read}, 32'd0);
        check("reset_no_write", {31'b0, acc_write}, 32'd0);
        check("reset_acc_din", acc_din, 32'd0);
        prod_q = '{-5};
        run_frame(1, 0, 0, 1'b0);

        // Randomized frames
        for (int f = 0; f < 25; f++) begin
            n = $urandom_range(0, 9);
            mode = $urandom_range(0, 2);
            for (int i = 0; i < n; i++) begin
                case (mode)
                    0:       prod_q.push_back(int'($urandom) >>> 2);
                    1:       prod_q.push_back(536870911 - int'($urandom_range(0, 1000)));
                    default: prod_q.push_back(-536870912 + int'($urandom_range(0, 1000)));
                endcase
            end
            run_frame(n, $urandom_range(0, 2), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
